// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch control stage.
//
// Sits between the PC register and the IF/ID boundary. It computes the
// next-PC value fed back into the PC register, issues at most one
// instruction-memory request at a time at the current PC, and queues the
// returned instructions (with their PCs) in a small FIFO for decode.
// A redirect from EX flushes the FIFO and discards any in-flight response.
//
// Parameters:
//   DEPTH          FIFO entries (power of two, >= 2); each entry is {pc, instr}
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   pc_i           current PC from the PC register
//   next_pc_o      D input for the PC register
//   imem_req_o     fetch request valid
//   imem_addr_o    fetch address (= pc_i)
//   imem_gnt_i     request accepted this cycle (handshake = req & gnt)
//   imem_rvalid_i  response valid (>= 1 cycle after grant)
//   imem_rdata_i   response instruction
//   redirect_i     branch/jump taken from EX
//   redirect_pc_i  redirect target (low two bits are forced to zero)
//   dec_valid_o    FIFO head valid
//   dec_ready_i    decode accepts head
//   dec_instr_o    head instruction
//   dec_pc_o       head PC
//
// Optional feature, enabled by defining FETCH_PERF_CNT_EN:
//   perf_inst_o    saturating count of dec_valid_o & dec_ready_i cycles
//   perf_flush_o   saturating count of redirect_i cycles
module fetch_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  output logic [31:0] next_pc_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [31:0] dec_instr_o,
  output logic [31:0] dec_pc_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_inst_o,
  output logic [31:0] perf_flush_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  // FIFO storage: bit 63:32 = pc, bit 31:0 = instr
  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          outstanding_q, outstanding_d;
  logic          drop_q, drop_d;
  logic [31:0]   req_pc_q, req_pc_d;

  logic hs;    // request handshake this cycle
  logic rsp;   // response that belongs to our outstanding request
  logic push;
  logic pop;

  // Request is suppressed during a redirect and whenever the FIFO has no
  // free slot, so a push can never overflow.
  assign imem_req_o  = !reset && !outstanding_q && !redirect_i && (count_q < DEPTH_C);
  assign imem_addr_o = pc_i;
  assign hs          = imem_req_o && imem_gnt_i;
  assign rsp         = imem_rvalid_i && outstanding_q;
  // A response landing in the redirect cycle belongs to the wrong path.
  assign push        = rsp && !drop_q && !redirect_i;

  assign dec_valid_o = (count_q != '0);
  assign dec_pc_o    = mem_q[rd_ptr_q][63:32];
  assign dec_instr_o = mem_q[rd_ptr_q][31:0];
  assign pop         = dec_valid_o && dec_ready_i && !redirect_i;

  always_comb begin
    if (redirect_i)
      next_pc_o = {redirect_pc_i[31:2], 2'b00};
    else if (hs)
      next_pc_o = pc_i + 32'd4;
    else
      next_pc_o = pc_i;
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    req_pc_d      = req_pc_q;

    if (hs) begin
      outstanding_d = 1'b1;
      req_pc_d      = pc_i;
    end else if (rsp) begin
      outstanding_d = 1'b0;
    end

    if (redirect_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      // If the response is still pending, its later arrival must be dropped;
      // if it arrives now it is consumed (and discarded) in this cycle.
      if (outstanding_q && !imem_rvalid_i)
        drop_d = 1'b1;
      else if (rsp)
        drop_d = 1'b0;
    end else begin
      if (rsp && drop_q)
        drop_d = 1'b0;
      if (push)
        wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)
        rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      req_pc_q      <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      req_pc_q      <= req_pc_d;
      if (push)
        mem_q[wr_ptr_q] <= {req_pc_q, imem_rdata_i};
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_inst_q, perf_inst_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_inst_d  = perf_inst_q;
    perf_flush_d = perf_flush_q;
    if (dec_valid_o && dec_ready_i && (perf_inst_q != 32'hFFFF_FFFF))
      perf_inst_d = perf_inst_q + 32'd1;
    if (redirect_i && (perf_flush_q != 32'hFFFF_FFFF))
      perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_inst_q  <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_inst_q  <= perf_inst_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_inst_o  = perf_inst_q;
  assign perf_flush_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl. The bench models the PC register
// (pc_i follows next_pc_o each clock) and drives the memory and decode
// handshakes by hand, one cycle at a time. Inputs change at posedge+1,
// outputs are checked at posedge+2.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_q;
  logic [31:0] next_pc_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_instr_o;
  logic [31:0] dec_pc_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_inst_o;
  logic [31:0] perf_flush_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // PC register driven by the DUT's next-PC output
  always @(posedge clk or posedge reset) begin
    if (reset) pc_q <= 32'd0;
    else       pc_q <= next_pc_o;
  end

  fetch_ctrl #(.DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_i          (pc_q),
    .next_pc_o     (next_pc_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_instr_o   (dec_instr_o),
    .dec_pc_o      (dec_pc_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_inst_o   (perf_inst_o),
    .perf_flush_o  (perf_flush_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance to the next drive point (just after the rising edge)
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs
  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic gnt, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic redir, input logic [31:0] rpc);
    imem_gnt_i    = gnt;
    imem_rvalid_i = rv;
    imem_rdata_i  = rd;
    dec_ready_i   = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc();
    settle();
    $display("reset: req=%0d valid=%0d next_pc=%08h", imem_req_o, dec_valid_o, next_pc_o);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, dec_valid_o}, 32'd0);
    chk("rst_next_pc", next_pc_o, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_inst", perf_inst_o, 32'd0);
    chk("rst_perf_flush", perf_flush_o, 32'd0);
`endif

    // ---- first fetch: grant at PC 0, response one cycle later ----
    cyc();
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    settle();
    $display("fetch0 grant: req=%0d addr=%08h next_pc=%08h", imem_req_o, imem_addr_o, next_pc_o);
    chk("f0_req", {31'd0, imem_req_o}, 32'd1);
    chk("f0_addr", imem_addr_o, 32'd0);
    chk("f0_next_pc", next_pc_o, 32'd4);
    cyc();
    drive(1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
    settle();
    $display("fetch0 rvalid: req=%0d valid=%0d next_pc=%08h", imem_req_o, dec_valid_o, next_pc_o);
    chk("f0_rsp_req", {31'd0, imem_req_o}, 32'd0);
    chk("f0_rsp_valid", {31'd0, dec_valid_o}, 32'd0);
    chk("f0_rsp_next_pc", next_pc_o, 32'd4);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    settle();
    $display("fetch0 deliver: valid=%0d instr=%08h pc=%08h", dec_valid_o, dec_instr_o, dec_pc_o);
    chk("f0_valid", {31'd0, dec_valid_o}, 32'd1);
    chk("f0_instr", dec_instr_o, 32'h0000_0013);
    chk("f0_pc", dec_pc_o, 32'd0);
    chk("f0_req_again", {31'd1 & 31'd0, imem_req_o}, 32'd1);
    cyc();
    settle();
    chk("f0_popped", {31'd0, dec_valid_o}, 32'd0);

    // ---- fill FIFO with decode stalled (redirect to 0 first) ----
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    settle();
    $display("redirect to 0: next_pc=%08h req=%0d", next_pc_o, imem_req_o);
    chk("r0_next_pc", next_pc_o, 32'd0);
    chk("r0_req", {31'd0, imem_req_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      settle();
      $display("fill %0d grant: req=%0d addr=%08h next_pc=%08h", i, imem_req_o, imem_addr_o, next_pc_o);
      chk("fill_req", {31'd0, imem_req_o}, 32'd1);
      chk("fill_addr", imem_addr_o, 32'(4 * i));
      chk("fill_next_pc", next_pc_o, 32'(4 * i + 4));
      cyc();
      drive(1'b1, 1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0, 32'h0);
      settle();
      chk("fill_rsp_req", {31'd0, imem_req_o}, 32'd0);
    end
    cyc();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    settle();
    $display("full: req=%0d next_pc=%08h valid=%0d head_pc=%08h", imem_req_o, next_pc_o, dec_valid_o, dec_pc_o);
    chk("full_req", {31'd0, imem_req_o}, 32'd0);
    chk("full_next_pc", next_pc_o, 32'h10);
    chk("full_valid", {31'd0, dec_valid_o}, 32'd1);
    cyc();
    settle();
    chk("full_req_held", {31'd0, imem_req_o}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      settle();
      $display("drain %0d: valid=%0d pc=%08h instr=%08h", i, dec_valid_o, dec_pc_o, dec_instr_o);
      chk("drain_valid", {31'd0, dec_valid_o}, 32'd1);
      chk("drain_pc", dec_pc_o, 32'(4 * i));
      chk("drain_instr", dec_instr_o, 32'h1000 + 32'(i));
      cyc();
    end
    settle();
    chk("drain_empty", {31'd0, dec_valid_o}, 32'd0);

    // ---- redirect while a request at 0x10 is outstanding ----
    cyc();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    settle();
    chk("rd_addr", imem_addr_o, 32'h10);
    cyc();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h103);
    settle();
    $display("redirect 0x103: next_pc=%08h req=%0d", next_pc_o, imem_req_o);
    chk("rd_next_pc", next_pc_o, 32'h100);
    chk("rd_req", {31'd0, imem_req_o}, 32'd0);
    cyc();
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    settle();
    chk("rd_stale_req", {31'd0, imem_req_o}, 32'd0);
    chk("rd_empty", {31'd0, dec_valid_o}, 32'd0);
    cyc();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    settle();
    $display("after stale rsp: valid=%0d req=%0d addr=%08h", dec_valid_o, imem_req_o, imem_addr_o);
    chk("rd_dropped", {31'd0, dec_valid_o}, 32'd0);
    chk("rd_new_req", {31'd0, imem_req_o}, 32'd1);
    chk("rd_new_addr", imem_addr_o, 32'h100);
    cyc();
    drive(1'b0, 1'b1, 32'h0000_AAAA, 1'b1, 1'b0, 32'h0);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    settle();
    $display("target deliver: valid=%0d pc=%08h instr=%08h", dec_valid_o, dec_pc_o, dec_instr_o);
    chk("rd_tgt_valid", {31'd0, dec_valid_o}, 32'd1);
    chk("rd_tgt_pc", dec_pc_o, 32'h100);
    chk("rd_tgt_instr", dec_instr_o, 32'h0000_AAAA);

    // ---- redirect coinciding with rvalid and a pop ----
    cyc();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);   // request at 0x104
    settle();
    chk("rv_addr", imem_addr_o, 32'h104);
    cyc();
    drive(1'b0, 1'b1, 32'h0000_00B1, 1'b0, 1'b0, 32'h0);
    cyc();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);   // request at 0x108
    settle();
    chk("rv_addr2", imem_addr_o, 32'h108);
    cyc();
    drive(1'b1, 1'b1, 32'h0000_0BAD, 1'b1, 1'b1, 32'h200);
    settle();
    $display("redirect+rvalid: req=%0d valid=%0d head=%08h next_pc=%08h", imem_req_o, dec_valid_o, dec_pc_o, next_pc_o);
    chk("rv_req", {31'd0, imem_req_o}, 32'd0);
    chk("rv_valid", {31'd0, dec_valid_o}, 32'd1);
    chk("rv_head", dec_pc_o, 32'h104);
    chk("rv_next_pc", next_pc_o, 32'h200);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    settle();
    $display("after redirect+rvalid: valid=%0d req=%0d addr=%08h", dec_valid_o, imem_req_o, imem_addr_o);
    chk("rv_flushed", {31'd0, dec_valid_o}, 32'd0);
    chk("rv_req_after", {31'd0, imem_req_o}, 32'd1);
    chk("rv_addr_after", imem_addr_o, 32'h200);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_flush_cnt", perf_flush_o, 32'd3);
`endif

    // ---- PC wrap at the top of the address space ----
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    settle();
    chk("wr_redir_pc", next_pc_o, 32'hFFFF_FFFC);
    cyc();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    settle();
    $display("wrap grant: addr=%08h next_pc=%08h", imem_addr_o, next_pc_o);
    chk("wr_addr", imem_addr_o, 32'hFFFF_FFFC);
    chk("wr_next_pc", next_pc_o, 32'h0);
    cyc();
    drive(1'b0, 1'b1, 32'h0000_0077, 1'b1, 1'b0, 32'h0);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    settle();
    chk("wr_pc", dec_pc_o, 32'hFFFF_FFFC);
    chk("wr_instr", dec_instr_o, 32'h0000_0077);

    // ---- reset while outstanding, late rvalid ignored ----
    cyc();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    settle();
    chk("rs_req", {31'd0, imem_req_o}, 32'd1);
    cyc();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    settle();
    chk("rs_req_in_reset", {31'd0, imem_req_o}, 32'd0);
    chk("rs_valid_in_reset", {31'd0, dec_valid_o}, 32'd0);
    cyc();
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'h0000_0055, 1'b1, 1'b0, 32'h0);
    settle();
    chk("rs_req_release", {31'd1 & 31'd0, imem_req_o}, 32'd1);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    settle();
    $display("after reset+late rvalid: valid=%0d", dec_valid_o);
    chk("rs_no_push", {31'd0, dec_valid_o}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rs_perf_inst", perf_inst_o, 32'd0);
    chk("rs_perf_flush", perf_flush_o, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch control stage sitting around the PC register: computes the next-PC value fed back into it, issues instruction-memory requests at the current PC, and buffers returned instructions in a small FIFO for the decode stage. It sits between the PC register and the IF/ID boundary. It also absorbs branch/jump redirects from EX by flushing the FIFO and discarding any in-flight response.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2); each entry holds {pc, instr}
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- pc_i  in  32  current PC from the PC register
- next_pc_o  out  32  D input for the PC register
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  fetch address (= pc_i)
- imem_gnt_i  in  1  request accepted this cycle (handshake = req & gnt)
- imem_rvalid_i  in  1  response valid (≥1 cycle after grant)
- imem_rdata_i  in  32  response instruction
- redirect_i  in  1  branch/jump taken from EX
- redirect_pc_i  in  32  redirect target
- dec_valid_o  out  1  FIFO head valid
- dec_ready_i  in  1  decode accepts head
- dec_instr_o  out  32  head instruction
- dec_pc_o  out  32  head PC

## Operation
- State: FIFO (wr/rd pointers, count 0..DEPTH), outstanding flag, drop flag, req_pc register.
- Max one outstanding request. imem_req_o = !reset & !outstanding & !redirect_i & (count < DEPTH). imem_addr_o = pc_i.
- On req & gnt: outstanding←1, req_pc←pc_i.
- On imem_rvalid_i with outstanding: outstanding←0; if drop=0, push {req_pc, imem_rdata_i}; if drop=1, discard and drop←0. rvalid without outstanding is ignored.
- Credit rule: request only issued when count < DEPTH, so push never overflows (a pop in the same cycle does not grant credit until next cycle).
- next_pc_o priority: redirect_i → {redirect_pc_i[31:2],2'b00}; else req & gnt → pc_i + 4 (mod 2^32, wraps 0xFFFFFFFC→0); else pc_i.
- Pop on dec_valid_o & dec_ready_i. dec_valid_o = (count ≠ 0); dec_instr_o/dec_pc_o = head entry (don't-care when invalid).
- Redirect (redirect_i=1): FIFO flushed (count←0, pointers←0) at the edge; if outstanding and rvalid not arriving this cycle, drop←1; rvalid in the redirect cycle is discarded; pop in same cycle ignored; no request issued.
- Simultaneous push and pop: both occur, count unchanged.

## Timing
- Reset values: count 0, pointers 0, outstanding 0, drop 0, req_pc 0; dec_valid_o 0, imem_req_o 0, next_pc_o = pc_i. Reset mid-request abandons it; a late rvalid after reset is ignored (outstanding=0).
- Grant at cycle N, rvalid at N+k (k≥1): entry visible on dec_valid_o at N+k+1.
- Next request may be asserted in the cycle after rvalid; best-case throughput with k=1 is one instruction per 2 cycles.
- Redirect at cycle R: dec_valid_o=0 at R+1; PC register holds target at R+1; first request to target at R+1 (if no undropped-outstanding constraint: outstanding must clear first, drop response consumed).
- next_pc_o, imem_req_o, imem_addr_o, dec_* outputs are combinational from registered state and inputs listed above; no comb path from imem_rdata_i to any output.

## Configuration
- FETCH_PERF_CNT_EN: when defined, adds outputs perf_inst_o[31:0] (counts dec_valid_o & dec_ready_i) and perf_flush_o[31:0] (counts redirect_i cycles), both reset to 0 and saturating at 0xFFFFFFFF. When undefined, ports and counters are absent; all other behaviour identical.

## Test plan
- Reset with pc_i=0, gnt=1, rvalid 1 cycle later with 0x00000013, dec_ready=1 -> dec_valid_o rises 2 cycles after grant with instr 0x00000013, pc 0; next_pc_o=4 in grant cycle.
- dec_ready=0, memory always grants, k=1 -> FIFO fills to 4 entries (PCs 0,4,8,C), imem_req_o held 0 afterwards, next_pc_o=pc_i; release ready -> entries drain in order.
- Request outstanding at PC 0x10, redirect_i to 0x103 before rvalid -> next_pc_o=0x100, FIFO empty next cycle, stale response discarded, first delivered entry has pc 0x100.
- redirect_i in same cycle as rvalid and full FIFO pop -> response discarded, count 0 next cycle, no request in redirect cycle.
- pc_i=0xFFFFFFFC granted -> next_pc_o=0x00000000.
- Assert reset while outstanding, rvalid arrives during reset release -> no push, dec_valid_o stays 0; with FETCH_PERF_CNT_EN, perf_inst_o and perf_flush_o read 0.
